// File: rtl/taxi_apb_pkg.sv
// Shared APB completer definitions: FSM state and error encodings, plus the
// helper that turns a data width into the byte-address to word-index shift.
package taxi_apb_pkg;

    typedef enum logic [1:0] {
        APB_ST_IDLE = 2'd0,
        APB_ST_WAIT = 2'd1,
        APB_ST_DONE = 2'd2
    } apb_state_t;

    typedef enum logic [1:0] {
        APB_ERR_OK       = 2'd0,
        APB_ERR_DECODE   = 2'd1,
        APB_ERR_RO_WRITE = 2'd2
    } apb_err_t;

    function automatic int apb_word_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/taxi_apb_reg_bank_decode.sv
// Word-index decoder for an RW block followed by an RO block; reports hits,
// the error class and the index relative to the block that was hit.
module taxi_apb_reg_bank_decode
    import taxi_apb_pkg::*;
#(
    parameter int RW_COUNT = 8,
    parameter int RO_COUNT = 8,
    parameter int IDX_W    = 14
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             write,
    output logic             rw_hit,
    output logic             ro_hit,
    output apb_err_t         err,
    output logic [IDX_W-1:0] sel
);

    // One extra bit keeps the range compares safe when IDX_W is 32.
    logic [32:0] idx_ext_s;

    // Classify the index against the RW and RO windows
    always_comb begin
        idx_ext_s = 33'(idx);
        rw_hit    = 1'b0;
        ro_hit    = 1'b0;
        err       = APB_ERR_OK;
        sel       = idx;
        if (idx_ext_s < 33'(RW_COUNT)) begin
            rw_hit = 1'b1;
        end else if (idx_ext_s < 33'(RW_COUNT + RO_COUNT)) begin
            ro_hit = 1'b1;
            sel    = idx - IDX_W'(RW_COUNT);
            err    = write ? APB_ERR_RO_WRITE : APB_ERR_OK;
        end else begin
            err = APB_ERR_DECODE;
        end
    end

endmodule

// File: rtl/taxi_apb_reg_bank.sv
// APB completer with RW control and RO status registers and a fixed number of
// wait states; pready, pslverr and prdata all come straight from flops.
module taxi_apb_reg_bank
    import taxi_apb_pkg::*;
#(
    parameter int               RW_COUNT    = 8,
    parameter int               RO_COUNT    = 8,
    parameter int               WAIT_STATES = 0,
    parameter int               DATA_W      = 32,
    parameter int               ADDR_W      = 16,
    parameter int               STRB_W      = DATA_W / 8,
    parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_apb_psel,
    input  logic                         s_apb_penable,
    input  logic                         s_apb_pwrite,
    input  logic [ADDR_W-1:0]            s_apb_paddr,
    input  logic [DATA_W-1:0]            s_apb_pwdata,
    input  logic [STRB_W-1:0]            s_apb_pstrb,
    output logic                         s_apb_pready,
    output logic [DATA_W-1:0]            s_apb_prdata,
    output logic                         s_apb_pslverr,
    output logic [RW_COUNT*DATA_W-1:0]   reg_out,
    output logic [RW_COUNT-1:0]          reg_wr_stb,
    input  logic [RO_COUNT*DATA_W-1:0]   reg_in
);

    localparam int SHIFT = apb_word_shift(DATA_W);
    localparam int IDX_W = ADDR_W - SHIFT;

    apb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] reg_q [RW_COUNT];
    logic [DATA_W-1:0] reg_d [RW_COUNT];
    logic [RW_COUNT-1:0] wr_stb_q, wr_stb_d;

    logic [IDX_W-1:0]  paddr_idx_s;
    logic [IDX_W-1:0]  dec_idx_s;
    logic              dec_write_s;
    logic              rw_hit_s;
    logic              ro_hit_s;
    apb_err_t          err_s;
    logic [IDX_W-1:0]  dec_sel_s;
    logic [DATA_W-1:0] rdata_s;
    logic              addr_unused_s;

    assign paddr_idx_s   = s_apb_paddr[ADDR_W-1:SHIFT];
    assign addr_unused_s = ^s_apb_paddr;

    // In IDLE the live setup address is decoded so a zero-wait transfer can
    // enter DONE directly; afterwards the latched transfer is decoded.
    always_comb begin
        dec_idx_s   = (state_q == APB_ST_IDLE) ? paddr_idx_s  : idx_q;
        dec_write_s = (state_q == APB_ST_IDLE) ? s_apb_pwrite : write_q;
    end

    taxi_apb_reg_bank_decode #(
        .RW_COUNT (RW_COUNT),
        .RO_COUNT (RO_COUNT),
        .IDX_W    (IDX_W)
    ) u_decode (
        .idx    (dec_idx_s),
        .write  (dec_write_s),
        .rw_hit (rw_hit_s),
        .ro_hit (ro_hit_s),
        .err    (err_s),
        .sel    (dec_sel_s)
    );

    // Read mux over both register blocks
    always_comb begin
        rdata_s = '0;
        for (int i = 0; i < RW_COUNT; i++) begin
            rdata_s = (rw_hit_s && dec_sel_s == IDX_W'(i)) ? reg_q[i] : rdata_s;
        end
        for (int i = 0; i < RO_COUNT; i++) begin
            rdata_s = (ro_hit_s && dec_sel_s == IDX_W'(i)) ? reg_in[i*DATA_W +: DATA_W] : rdata_s;
        end
    end

    // Transfer FSM, byte-lane write commit and registered bus responses
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        reg_d    = reg_q;
        wr_stb_d = '0;
        case (state_q)
            APB_ST_IDLE: begin
                if (s_apb_psel && !s_apb_penable) begin
                    idx_d   = paddr_idx_s;
                    write_d = s_apb_pwrite;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? APB_ST_DONE : APB_ST_WAIT;
                end else begin
                    state_d = APB_ST_IDLE;
                end
            end
            APB_ST_WAIT: begin
                if (!s_apb_psel) begin
                    state_d = APB_ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? APB_ST_DONE : APB_ST_WAIT;
                end
            end
            APB_ST_DONE: begin
                state_d = APB_ST_IDLE;
                if (write_q && err_s == APB_ERR_OK) begin
                    for (int i = 0; i < RW_COUNT; i++) begin
                        wr_stb_d[i] = (dec_sel_s == IDX_W'(i));
                        for (int b = 0; b < STRB_W; b++) begin
                            reg_d[i][b*8 +: 8] = (wr_stb_d[i] && s_apb_pstrb[b]) ?
                                s_apb_pwdata[b*8 +: 8] : reg_q[i][b*8 +: 8];
                        end
                    end
                end else begin
                    wr_stb_d = '0;
                end
            end
            default: begin
                state_d = APB_ST_IDLE;
            end
        endcase

        pready_d  = (state_d == APB_ST_DONE);
        pslverr_d = pready_d && (err_s != APB_ERR_OK);
        prdata_d  = (pready_d && err_s == APB_ERR_OK && !dec_write_s) ? rdata_s : '0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= APB_ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_stb_q  <= '0;
            for (int i = 0; i < RW_COUNT; i++) begin
                reg_q[i] <= RST_VAL;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            wr_stb_q  <= wr_stb_d;
            for (int i = 0; i < RW_COUNT; i++) begin
                reg_q[i] <= reg_d[i];
            end
        end
    end

    assign s_apb_pready  = pready_q;
    assign s_apb_pslverr = pslverr_q;
    assign s_apb_prdata  = prdata_q;
    assign reg_wr_stb    = wr_stb_q;

    for (genvar g = 0; g < RW_COUNT; g++) begin : g_reg_out
        assign reg_out[g*DATA_W +: DATA_W] = reg_q[g];
    end

endmodule
